// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiplier and its result streamer.
// Index widths and flattened element offsets live here so both sides agree.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // clog2 with a floor of 1 so single-row/column matrices still get a bit
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int elem_off(input int m, input int n, input int cols);
        return m * cols + n;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Full-throughput output register slice with unsigned saturation
// applied to the incoming element before it is captured.
module stream_out_reg #(
    parameter int IW = 32,
    parameter int OW = 32,
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic [SW-1:0] in_side,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_sat,
    output logic [SW-1:0] out_side
);

    logic [OW-1:0] nar;
    logic          sat;

    generate
        if (OW < IW) begin : g_sat
            assign sat = |in_data[IW-1:OW];
            assign nar = sat ? {OW{1'b1}} : in_data[OW-1:0];
        end else begin : g_pass
            assign sat = 1'b0;
            assign nar = in_data[OW-1:0];
        end
    endgenerate

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_side  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= nar;
                out_sat  <= sat;
                out_side <= in_side;
            end
        end
    end

endmodule

// File: rtl/matmul_result_streamer.sv
// Drains the flattened multiplier result as a valid/ready stream,
// row-major or column-major, narrowed with unsigned saturation.
module matmul_result_streamer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 21,
    parameter int N          = 21,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter bit COL_MAJOR  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [M*N*2*DATA_WIDTH-1:0] result,
    output logic                        busy,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_WIDTH-1:0]        m_data,
    output logic [idx_w(M)-1:0]         m_row,
    output logic [idx_w(N)-1:0]         m_col,
    output logic                        m_eol,
    output logic                        m_last,
    output logic                        m_sat,
    output logic                        done,
    output logic                        err_start
);

    localparam int IW = 2 * DATA_WIDTH;
    localparam int RW = idx_w(M);
    localparam int CW = idx_w(N);
    localparam int SW = RW + CW + 2;
    localparam logic [RW-1:0] RMAX = RW'(M - 1);
    localparam logic [CW-1:0] CMAX = CW'(N - 1);

    state_t        state;
    logic [RW-1:0] r, ld_r, nxt_r;
    logic [CW-1:0] c, ld_c, nxt_c;
    logic          more;
    logic          ld_eol, ld_last;
    logic          in_valid, in_ready, load, hs;
    logic [IW-1:0] elem;
    logic [SW-1:0] side;

    // r/c always point at the next element to feed into the slice
    always_comb begin
        ld_r    = (state == STREAM) ? r : '0;
        ld_c    = (state == STREAM) ? c : '0;
        ld_last = (ld_r == RMAX) && (ld_c == CMAX);
        nxt_r   = ld_r;
        nxt_c   = ld_c;
        if (COL_MAJOR) begin
            ld_eol = (ld_r == RMAX);
            if (ld_eol) begin
                nxt_r = '0;
                nxt_c = ld_c + 1'b1;
            end else begin
                nxt_r = ld_r + 1'b1;
            end
        end else begin
            ld_eol = (ld_c == CMAX);
            if (ld_eol) begin
                nxt_c = '0;
                nxt_r = ld_r + 1'b1;
            end else begin
                nxt_c = ld_c + 1'b1;
            end
        end
    end

    assign elem     = result[elem_off(int'(ld_r), int'(ld_c), N)*IW +: IW];
    assign in_valid = ((state == IDLE) && start) || ((state == STREAM) && more);
    assign load     = in_valid && in_ready;
    assign hs       = m_valid && m_ready;

    stream_out_reg #(
        .IW(IW),
        .OW(OUT_WIDTH),
        .SW(SW)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (elem),
        .in_side  ({ld_r, ld_c, ld_eol, ld_last}),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .out_sat  (m_sat),
        .out_side (side)
    );

    assign {m_row, m_col, m_eol, m_last} = side;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            more      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_start <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && (state != IDLE))
                err_start <= 1'b1;
            if (load) begin
                r    <= nxt_r;
                c    <= nxt_c;
                more <= !ld_last;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (hs && m_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed and table-driven checks of the result streamer: full 21x21
// drain, saturated narrow output, 2x2 column-major, stalls, errors, reset.
module tb_matmul_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, rdy0, start2, rdy2;
    logic [21*21*32-1:0] res0;
    logic [127:0] res2;

    logic busy0, v0, eol0, last0, sat0, done0, err0;
    logic [31:0] d0;
    logic [4:0] r0, c0;
    logic busy1, v1, eol1, last1, sat1, done1, err1;
    logic [15:0] d1;
    logic [4:0] r1, c1;
    logic busy2, v2, eol2, last2, sat2, done2, err2;
    logic [31:0] d2;
    logic [0:0] r2, c2;

    matmul_result_streamer u0 (
        .clk(clk), .rst(rst), .start(start0), .result(res0),
        .busy(busy0), .m_valid(v0), .m_ready(rdy0), .m_data(d0),
        .m_row(r0), .m_col(c0), .m_eol(eol0), .m_last(last0),
        .m_sat(sat0), .done(done0), .err_start(err0)
    );

    matmul_result_streamer #(.OUT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .start(start0), .result(res0),
        .busy(busy1), .m_valid(v1), .m_ready(rdy0), .m_data(d1),
        .m_row(r1), .m_col(c1), .m_eol(eol1), .m_last(last1),
        .m_sat(sat1), .done(done1), .err_start(err1)
    );

    matmul_result_streamer #(.M(2), .N(2), .COL_MAJOR(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .result(res2),
        .busy(busy2), .m_valid(v2), .m_ready(rdy2), .m_data(d2),
        .m_row(r2), .m_col(c2), .m_eol(eol2), .m_last(last2),
        .m_sat(sat2), .done(done2), .err_start(err2)
    );

    typedef struct {
        bit st; bit rdy;
        bit v; int d; int r; int c; bit eol; bit last; bit busy; bit done;
    } vec_t;

    longint cexp [441];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_stream(input bit rnd, input int errat);
        int idx = 0;
        int cyc = 0;
        bit seen = 0;
        bit stall = 0;
        bit rdy;
        logic [63:0] snap = '0;
        longint e;
        start0 = 1'b1;
        rdy0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        while (!seen && cyc < 5000) begin
            if (stall)
                chk("stable", {18'd0, v0, d0, r0, c0, eol0, last0, sat0}, snap);
            if (done0) begin
                seen = 1;
                chk("count", idx, 441);
                chk("busy_at_done", busy0, 0);
                chk("valid_at_done", v0, 0);
                if (!rnd) chk("done_cycle", cyc, 441);
            end else if (!v0) begin
                chk("valid_in_stream", v0, 1);
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                rdy0 = rdy;
                start0 = (cyc == errat);
                if (rdy) begin
                    e = cexp[idx];
                    chk("row", r0, idx / 21);
                    chk("col", c0, idx % 21);
                    chk("data", d0, e);
                    chk("eol", eol0, (idx % 21) == 20);
                    chk("last", last0, idx == 440);
                    chk("busy", busy0, 1);
                    chk("data16", d1, (e > 65535) ? 65535 : e);
                    chk("sat16", sat1, e > 65535);
                    idx++;
                end
                snap = {18'd0, v0, d0, r0, c0, eol0, last0, sat0};
                stall = !rdy;
            end
            @(posedge clk); #1;
            start0 = 1'b0;
            cyc++;
        end
        if (!seen) chk("timeout_done", 0, 1);
        rdy0 = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t tv [8];
    longint s;

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        rdy0 = 1'b0;
        rdy2 = 1'b0;
        res0 = '0;
        res2 = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int m = 0; m < 21; m++)
            for (int n = 0; n < 21; n++) begin
                s = 0;
                for (int k = 0; k < 21; k++)
                    s += longint'(m * 21 + k) * longint'(k * 21 + n);
                cexp[m*21+n] = s;
                res0[(m*21+n)*32 +: 32] = s[31:0];
            end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", v0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_data", d0, 0);
        chk("rst_row", r0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_valid2", v2, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2x2 column-major, with stalls
        tv[0] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        tv[1] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        tv[2] = '{0, 1, 1, 3, 1, 0, 1, 0, 1, 0};
        tv[3] = '{0, 1, 1, 2, 0, 1, 0, 0, 1, 0};
        tv[4] = '{0, 0, 1, 2, 0, 1, 0, 0, 1, 0};
        tv[5] = '{0, 1, 1, 4, 1, 1, 1, 1, 1, 0};
        tv[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[7] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            start2 = tv[i].st;
            rdy2 = tv[i].rdy;
            @(posedge clk); #1;
            start2 = 1'b0;
            chk("t_valid", v2, tv[i].v);
            chk("t_busy", busy2, tv[i].busy);
            chk("t_done", done2, tv[i].done);
            if (tv[i].v) begin
                chk("t_data", d2, tv[i].d);
                chk("t_row", r2, tv[i].r);
                chk("t_col", c2, tv[i].c);
                chk("t_eol", eol2, tv[i].eol);
                chk("t_last", last2, tv[i].last);
                chk("t_sat", sat2, 0);
            end
        end
        chk("t_err", err2, 0);

        run_stream(1'b0, -1);
        chk("err_clean", err0, 0);

        run_stream(1'b1, 10);
        chk("err_set", err0, 1);
        chk("err_set16", err1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", err0, 1);

        // reset after five handshakes
        start0 = 1'b1;
        rdy0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_col", c0, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_data", d0, 0);
        chk("mid_rst_col", c0, 0);
        chk("mid_rst_eol", eol0, 0);
        chk("mid_rst_last", last0, 0);
        chk("mid_rst_sat", sat0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_err", err0, 0);
        chk("mid_rst_data16", d1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_stream(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_result_streamer.md
# matmul_result_streamer

Drains the flattened result matrix of the task-based matrix multiplier into a valid/ready stream, one element per handshake, in row-major or column-major order. It is the read side of the multiplier's result bus: it sits between `top` and any downstream consumer (DMA, UART bridge, checker) and replaces hierarchical result dumps with a proper stream interface. It also narrows elements to a configurable output width with unsigned saturation.

## Interface
- `DATA_WIDTH`, 16: operand width; result elements are 2*DATA_WIDTH bits
- `M`, 21: result rows
- `N`, 21: result columns
- `OUT_WIDTH`, 2*DATA_WIDTH: streamed element width, 1..2*DATA_WIDTH
- `COL_MAJOR`, 0: 0 = row-major order, 1 = column-major order

- `clk` in 1: clock, rising edge
- `rst` in 1: reset rst, synchronous, active-high
- `start` in 1: one-cycle pulse from the multiplier's done event
- `result` in M*N*2*DATA_WIDTH: flattened result; element (m,n) at bits [(m*N+n)*2*DATA_WIDTH +: 2*DATA_WIDTH]
- `busy` out 1: streaming in progress; `result` must be held stable while high
- `m_valid` out 1: stream element valid
- `m_ready` in 1: consumer ready
- `m_data` out OUT_WIDTH: element value, saturated
- `m_row` out clog2(M): row index of `m_data`
- `m_col` out clog2(N): column index of `m_data`
- `m_eol` out 1: last element of a row (row-major) or column (column-major)
- `m_last` out 1: last element of the matrix
- `m_sat` out 1: current `m_data` was saturated
- `done` out 1: one-cycle pulse after the final handshake
- `err_start` out 1: sticky; `start` seen while busy; cleared only by `rst`

## Operation
- FSM: IDLE, STREAM, DONE.
- IDLE: `start` → load row/col counters to (0,0), register element (0,0) into the output slice, go to STREAM.
- STREAM: handshake = `m_valid && m_ready`. On a handshake that is not the last, advance the inner counter (col for row-major, row for column-major), wrap it at N-1/M-1 and step the outer counter, and load the next element. On the handshake with `m_last`, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Saturation: if `OUT_WIDTH < 2*DATA_WIDTH` and element > 2^OUT_WIDTH−1, `m_data` = 2^OUT_WIDTH−1 and `m_sat` = 1; otherwise the value is zero-extended or passed through unchanged and `m_sat` = 0. Elements are unsigned.
- `m_eol` = inner index at its maximum. `m_last` = (M-1, N-1).
- `start` in STREAM or DONE: ignored, sets `err_start`. `start` in IDLE in the same cycle as leaving DONE: accepted.
- M=1 or N=1: wrap logic must still hold. For a 1×1 matrix, `m_eol` and `m_last` are both high on the only element.

## Timing
- Reset values: `busy`, `m_valid`, `m_data`, `m_row`, `m_col`, `m_eol`, `m_last`, `m_sat`, `done`, `err_start` all 0; FSM in IDLE.
- `start` at edge t → `m_valid` = 1 and `busy` = 1 from t+1.
- With `m_ready` held high: one element per cycle, M*N cycles total. `done` is high at t+1+M*N, and `busy` is 0 in that same cycle.
- `m_valid` is never deasserted without a handshake. `m_data`, `m_row`, `m_col`, `m_eol`, `m_last` and `m_sat` are stable while `m_valid && !m_ready`.
- All outputs are registered. `m_valid` does not depend combinationally on `m_ready`.
- `rst` asserted mid-stream → all outputs return to reset values at the next edge; the partial stream is dropped.

## Structure
- `matmul_pkg` holds the FSM state enum, the index-width function (clog2 with minimum 1) and the element-offset function used by both `top` and this block.
- One sub-module: `stream_out_reg`, an output register slice (data + sideband, valid/ready, full throughput). It holds the saturation and zero-extension logic on its input side.

## Test plan
- Default params, A[m][k]=m*21+k, B[k][n]=k*21+n, `m_ready`=1 → 441 elements. First `m_data`=60270 at (0,0), second 60480 at (0,1), last 2093070 at (20,20) with `m_last`=1; `done` at start+442.
- Same data, `OUT_WIDTH`=16 → (0,0)=60270 with `m_sat`=0; (20,20)=65535 with `m_sat`=1.
- M=N=2, `COL_MAJOR`=1, result {1,2,3,4} → order 1,3,2,4. `m_eol` on the 2nd and 4th elements; `m_last` on the 4th only.
- Random `m_ready` (50%) → no element lost or duplicated, outputs stable during stalls, sequence matches the reference ordering.
- `start` pulsed during STREAM → stream unaffected, `err_start`=1 until `rst`.
- `rst` asserted after 5 handshakes → next cycle all outputs 0. A new `start` then streams again from (0,0).
